// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions; holds the memory arbiter state encoding.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side request/response and RAM-side signals shared by the memory arbiter.
// slave: the arbiter's view; master: the surrounding caches and RAM.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32
);

  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic              iwait;
  logic [ADDR_W-1:0] iload;

  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [ADDR_W-1:0] dstore;
  logic              dwait;
  logic [ADDR_W-1:0] dload;

  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [ADDR_W-1:0] ramstore;
  logic [ADDR_W-1:0] ramload;
  logic              ram_ready;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/mem_arbiter.sv
// Shares one RAM port between instruction fetch and data access; data has priority.
// Define ARB_FAIR_EN to cap consecutive data grants at MAX_DSTREAK while a fetch waits.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned MAX_DSTREAK = 4,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic            CLK,
  input  logic            nRST,
  mem_arbiter_if.slave    bus
);

  arb_state_t state;
  arb_state_t next_state;

  logic              d_req_c;
  logic              fair_force_c;
  logic              ram_ren_c;
  logic              ram_wen_c;
  logic [ADDR_W-1:0] ram_addr_c;
  logic [ADDR_W-1:0] ram_store_c;
  logic [ADDR_W-1:0] iload_c;
  logic [ADDR_W-1:0] dload_c;

  assign d_req_c = bus.dREN | bus.dWEN;

  // State register; reset discards any in-flight access.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Grant selection and RAM steering.
  always_comb begin
    next_state  = state;
    ram_ren_c   = 1'b0;
    ram_wen_c   = 1'b0;
    ram_addr_c  = '0;
    ram_store_c = '0;
    iload_c     = '0;
    dload_c     = '0;

    case (state)
      IDLE: begin
        if (fair_force_c) begin
          next_state = IACC;
        end else if (d_req_c) begin
          next_state = DACC;
        end else if (bus.iREN) begin
          next_state = IACC;
        end
      end

      IACC: begin
        ram_ren_c  = 1'b1;
        ram_addr_c = bus.iaddr;
        iload_c    = bus.ramload;
        if (bus.ram_ready || !bus.iREN) begin
          next_state = IDLE;
        end
      end

      DACC: begin
        ram_addr_c  = bus.daddr;
        ram_store_c = bus.dstore;
        // A simultaneous read and write request is served as the write.
        ram_wen_c   = bus.dWEN;
        ram_ren_c   = bus.dREN & ~bus.dWEN;
        dload_c     = bus.ramload;
        if (bus.ram_ready || !d_req_c) begin
          next_state = IDLE;
        end
      end

      default: begin
        next_state = IDLE;
      end
    endcase
  end

  assign bus.ramREN   = ram_ren_c;
  assign bus.ramWEN   = ram_wen_c;
  assign bus.ramaddr  = ram_addr_c;
  assign bus.ramstore = ram_store_c;
  assign bus.iload    = iload_c;
  assign bus.dload    = dload_c;
  assign bus.iwait    = bus.iREN & ~((state == IACC) & bus.ram_ready);
  assign bus.dwait    = d_req_c  & ~((state == DACC) & bus.ram_ready);

`ifdef ARB_FAIR_EN
  localparam int unsigned DSTREAK_W = $clog2(MAX_DSTREAK + 1);

  logic [DSTREAK_W-1:0] dstreak;

  assign fair_force_c = (dstreak == DSTREAK_W'(MAX_DSTREAK)) && bus.iREN;

  // Counts data grants taken over a waiting fetch; saturates at MAX_DSTREAK.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      dstreak <= '0;
    end else if (state == IDLE) begin
      if (next_state == IACC) begin
        dstreak <= '0;
      end else if (next_state == DACC) begin
        if (!bus.iREN) begin
          dstreak <= '0;
        end else if (dstreak != DSTREAK_W'(MAX_DSTREAK)) begin
          dstreak <= dstreak + DSTREAK_W'(1);
        end
      end
    end
  end
`else
  logic unused_max_dstreak_c;

  assign fair_force_c = 1'b0;
  // MAX_DSTREAK has no effect under strict data priority.
  assign unused_max_dstreak_c = (MAX_DSTREAK == 32'd0);
`endif

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Sequential arbiter sharing the single RAM port between the instruction-fetch requester (icache side) and the data requester (dcache side) of the pipelined datapath.
Grants one requester at a time and holds the grant until RAM completes or the requester withdraws.
Returns load data and wait signals to both sides.
Data side has priority; an optional fairness mechanism bounds instruction starvation.

Parameters:
MAX_DSTREAK, 4, consecutive data grants allowed while an instruction request is pending (used only with ARB_FAIR_EN)
ADDR_W, 32, address/data width

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous active-low reset
iREN  in  1  instruction read request
iaddr  in  32  instruction address, held stable while iwait=1
iwait  out  1  instruction request not yet complete
iload  out  32  instruction read data, valid when iREN=1 and iwait=0
dREN  in  1  data read request
dWEN  in  1  data write request
daddr  in  32  data address, held stable while dwait=1
dstore  in  32  data write value
dwait  out  1  data request not yet complete
dload  out  32  data read data, valid when dREN=1 and dwait=0
ramREN  out  1  RAM read strobe
ramWEN  out  1  RAM write strobe
ramaddr  out  32  RAM address
ramstore  out  32  RAM write data
ramload  in  32  RAM read data
ram_ready  in  1  RAM access complete this cycle (single-cycle pulse)

Behaviour:
- Clock and reset: one clock, CLK; asynchronous active-low reset, nRST. Reset forces state=IDLE and dstreak=0.
- States: IDLE, IACC, DACC. State is registered; all outputs are combinational from state and inputs.
- IDLE:
  - ram outputs: ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
  - If dREN|dWEN, go to DACC. Else if iREN, go to IACC. Else stay.
  - ARB_FAIR_EN override: if dstreak==MAX_DSTREAK and iREN, go to IACC instead.
- DACC:
  - ramaddr=daddr, ramstore=dstore.
  - ramWEN=dWEN; ramREN=dREN&~dWEN (write wins if both are set).
  - dload=ramload.
  - ram_ready=1: dwait=0 this cycle, go to IDLE.
  - dREN=dWEN=0 (abort): ram strobes drop immediately, go to IDLE.
- IACC:
  - ramREN=1, ramaddr=iaddr, iload=ramload.
  - ram_ready=1: iwait=0, go to IDLE.
  - iREN=0: abort, go to IDLE.
- Wait signals:
  - iwait = iREN & ~(state==IACC & ram_ready).
  - dwait = (dREN|dWEN) & ~(state==DACC & ram_ready).
  - During reset both waits follow the requests; all ram outputs are 0.
- Load outputs: iload and dload are 0 outside their grant state.
- Latency: minimum 2 cycles from request to wait deassert (grant cycle, then access cycle). A mandatory IDLE cycle after every completion prevents re-issuing a request the requester still holds.
- No preemption: a pending data request never interrupts IACC.
- ram_ready in IDLE is ignored.
- Reset mid-access: ram strobes drop asynchronously; the in-flight access is discarded.

Optional Feature:
- Macro ARB_FAIR_EN.
- When defined:
  - Saturating counter dstreak, width $clog2(MAX_DSTREAK+1).
  - Increments on each IDLE->DACC grant taken while iREN=1.
  - Clears on any IDLE->IACC grant, or on a data grant taken with iREN=0.
  - When dstreak==MAX_DSTREAK and iREN=1, IDLE grants IACC even if data is requesting.
- When undefined: strict data priority; dstreak is absent.

Decomposition:
- Add arb_state_t enum (IDLE, IACC, DACC) to cpu_types_pkg.
- MAX_DSTREAK stays a module parameter.
- No sub-module needed; the fairness counter is inline, under `ifdef.

Test Plan:
- Instruction read alone: iREN=1, iaddr=0x40, RAM readies 3 cycles after grant with ramload=0x8C010004 -> ramREN=1, ramaddr=0x40 in IACC; iwait drops in the ready cycle with iload=0x8C010004; IDLE next cycle.
- Simultaneous requests: iREN=1 and dWEN=1 (daddr=0x100, dstore=0xDEADBEEF) -> DACC first, ramWEN=1, ramstore=0xDEADBEEF; after ready, one IDLE cycle, then IACC.
- No preemption: dREN asserts while in IACC -> ramaddr stays iaddr until ram_ready; DACC follows after IDLE.
- Abort: dREN dropped mid-DACC before ram_ready -> ramREN=0 same cycle, IDLE next cycle, dwait=0.
- Async reset: nRST low mid-DACC -> ramWEN=0 immediately, state=IDLE, dstreak=0.
- ARB_FAIR_EN, MAX_DSTREAK=4: dREN and iREN held continuously -> exactly 4 data grants, then 1 instruction grant, pattern repeats. Without the macro, no instruction grant occurs.
